// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states and
// datapath mux select values.
package multi_cycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_BR    = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_ALU    = 2'd2;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_RS1 = 1'b1;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_ECALL);
  endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// Control FSM stepping each RV32I instruction through IF/ID/EX/MEM/WB and
// driving every datapath select and write enable; stalls in IF/MEM on mem_ready.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       is_ecall_halt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted,
  output logic [2:0] state
);

  state_t state_q, state_d;
  logic   rdy;

  assign rdy   = mem_ready | ~MEM_WAIT_EN;
  assign state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IF;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_source  = PCSRC_PC4;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    is_halted  = 1'b0;

    // Holding reset silences every output, so an in-flight access is abandoned.
    if (reset_n) begin
      case (state_q)
        ST_IF: begin
          mem_read = 1'b1;
          if (rdy) begin
            ir_write = 1'b1;
            state_d  = ST_ID;
          end
        end

        ST_ID: begin
          alu_src_b = SRCB_IMM;
          if (opcode == OP_ECALL) begin
            if (is_ecall_halt) begin
              state_d = ST_HALT;
            end else begin
              pc_write = 1'b1;
              state_d  = ST_IF;
            end
          end else if (!is_known_op(opcode)) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_EX;
          end
        end

        ST_EX: begin
          state_d = ST_IF;
          case (opcode)
            OP_R: begin
              alu_src_a = SRCA_RS1;
              alu_op    = ALU_FUNCT;
              state_d   = ST_WB;
            end
            OP_I: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_FUNCT;
              state_d   = ST_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              state_d   = ST_MEM;
            end
            OP_BRANCH: begin
              alu_src_a = SRCA_RS1;
              alu_op    = ALU_BR;
              pc_write  = 1'b1;
              pc_source = bcond ? PCSRC_ALUOUT : PCSRC_PC4;
            end
            OP_JAL: begin
              // Target was computed into ALUOut during ID.
              pc_write  = 1'b1;
              pc_source = PCSRC_ALUOUT;
              reg_write = 1'b1;
              pc_to_reg = 1'b1;
            end
            OP_JALR: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              pc_write  = 1'b1;
              pc_source = PCSRC_ALU;
              reg_write = 1'b1;
              pc_to_reg = 1'b1;
            end
            default: ;
          endcase
        end

        ST_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode == OP_LOAD);
          mem_write = (opcode == OP_STORE);
          if (rdy) begin
            if (opcode == OP_LOAD) begin
              state_d = ST_WB;
            end else begin
              pc_write = (opcode == OP_STORE);
              state_d  = ST_IF;
            end
          end
        end

        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OP_LOAD);
          pc_write   = 1'b1;
          state_d    = ST_IF;
        end

        ST_HALT: begin
          is_halted = 1'b1;
        end

        default: state_d = ST_IF;
      endcase
    end
  end

endmodule
